cordic_vectoring_iterative: RTL and testbench
=============================================

// Module: cordic_vectoring_iterative
// PURPOSE
// - Iterative CORDIC in vectoring mode; the inverse of the rotation-mode CORDIC in this design.
// - Drives y towards 0 and returns the vector magnitude and its accumulated angle, z_i + atan2(y_i, x_i).
// - Magnitude is not gain-compensated (gain K ~= 1.647).
// - Sits ahead of the rotation core; its outputs can be fed back to reconstruct the vector.
// PARAMETERS
// - N_FRAC  7  fractional bits; data ports are signed Q1.N_FRAC (N_FRAC+1 bits wide)
// - Fixed internally, not parameters:
//   - ITERATIONS = 6
//   - shifts 0..5
//   - angle table 32,18,9,5,2,1 (binary angle: 256 = 360 deg, 64 = 90 deg)
// PORTS
// - clk_i                    in   1         single clock, rising edge
// - rst_i                    in   1         asynchronous, active-low reset
// - x_i                      in   N_FRAC+1  signed x component
// - y_i                      in   N_FRAC+1  signed y component
// - z_i                      in   N_FRAC+1  signed start angle (binary angle)
// - data_in_valid_strobe_i   in   1         1-cycle strobe; x_i/y_i/z_i valid
// - x_o                      out  N_FRAC+1  K*|v|, saturated to 2^N_FRAC-1
// - y_o                      out  N_FRAC+1  residual y, saturated to the signed range
// - z_o                      out  N_FRAC+1  z_i + atan2(y_i, x_i), wraps modulo 2^(N_FRAC+1)
// - data_out_valid_strobe_o  out  1         1-cycle strobe; x_o/y_o/z_o valid
// - busy_o                   out  1         high while not in IDLE
// BEHAVIOUR
// - Reset (rst_i=0, takes effect immediately, no clock needed):
//   - all registers 0, state IDLE
//   - x_o=y_o=z_o=0, data_out_valid_strobe_o=0, busy_o=0
//   - reset mid-computation aborts it; no output strobe is produced.
// - Internal widths: x/y are signed W = N_FRAC+3 bits (sign-extended); z is N_FRAC+1 bits, modular.
// - FSM states: IDLE, CALC, OUTPUT.
// - IDLE: on data_in_valid_strobe_i=1, capture with quadrant pre-rotation, clear counter, go to CALC.
//   - x_i>=0         : x=x_i,  y=y_i,  z=z_i
//   - x_i<0, y_i>=0  : x=y_i,  y=-x_i, z=z_i+64
//   - x_i<0, y_i<0   : x=-y_i, y=x_i,  z=z_i-64
//   - Negating -2^N_FRAC is exact because W carries guard bits.
// - CALC: one micro-rotation per cycle, i = counter 0..5; x and y use the pre-update values.
//   - y>=0: x+=y>>>i; y-=x>>>i; z+=ANG[i]
//   - y<0 : x-=y>>>i; y+=x>>>i; z-=ANG[i]
//   - >>> is an arithmetic shift, truncating toward -inf.
//   - At i=5: register saturated results into x_o/y_o/z_o, set the output strobe, go to OUTPUT.
// - OUTPUT: strobe is high for exactly this cycle; clear it; go to IDLE.
// - Latency: input sampled at edge E0, iterations on E1..E6.
//   - Strobe and new outputs appear after E6, strobe drops after E7.
//   - busy_o is high from after E0 until after E7.
// - Outputs hold their last result until the next result or reset.
// - Input strobes in CALC or OUTPUT are ignored; no queueing.
//   - Maximum throughput is one vector per 8 cycles; a strobe is accepted again from IDLE.
// - Saturation on x_o/y_o only: clamp to [-2^N_FRAC, 2^N_FRAC-1]. z never saturates, it wraps.
// - Unused FSM encoding: go to IDLE.
// TESTING
// 1. x=64, y=0, z=0 -> one strobe 7 cycles after the input strobe; x_o=106, y_o=2, z_o=1.
// 2. x=-64, y=0, z=0 -> pre-rotation +64; z wraps through -128; x_o=106, y_o=-2, z_o=127.
// 3. x=127, y=127 -> x_o saturates to 127; z_o in 31..33 (45 deg).
//    Also x=-128, y=-128 -> x_o=127, z_o near -96.
// 4. Second strobe at cycles +1..+7 after an accepted one -> ignored.
//    Strobe in IDLE right after OUTPUT -> accepted.
//    Exactly one output strobe per accepted input.
// 5. Drop rst_i at cycle +3 of CALC -> all outputs 0 and busy_o=0 immediately, no strobe.
//    Next input computes correctly.
// 6. Random sweep of (x,y,z) -> z_o within +-3 of the model; x_o within +-3 of min(127, K*|v|).
//    Reference model is a bit-exact C/Python model of the above rules.

Source files
------------

// File: rtl/cordic_vectoring_iterative.sv
// Iterative vectoring-mode CORDIC: rotates (x,y) onto the +x axis six times, one step per
// clock, and returns the unscaled magnitude, the residual y and z_i + atan2(y_i, x_i).
module cordic_vectoring_iterative #(
  parameter int N_FRAC = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [N_FRAC:0]   x_i,
  input  logic signed [N_FRAC:0]   y_i,
  input  logic signed [N_FRAC:0]   z_i,
  input  logic                     data_in_valid_strobe_i,
  output logic signed [N_FRAC:0]   x_o,
  output logic signed [N_FRAC:0]   y_o,
  output logic signed [N_FRAC:0]   z_o,
  output logic                     data_out_valid_strobe_o,
  output logic                     busy_o
);

  localparam int DW    = N_FRAC + 1;
  localparam int W     = N_FRAC + 3;
  localparam int ITERS = 6;
  localparam logic [DW-1:0]       QTR  = DW'(1 << (N_FRAC - 1));
  localparam logic signed [W-1:0] MAXV = W'((1 << N_FRAC) - 1);
  localparam logic signed [W-1:0] MINV = W'(-(1 << N_FRAC));

  typedef enum logic [1:0] {IDLE, CALC, OUTPUT} state_e;

  state_e                state_q;
  logic signed [W-1:0]   x_q, y_q;
  logic [DW-1:0]         z_q;
  logic [2:0]            cnt_q;
  logic signed [DW-1:0]  xo_q, yo_q, zo_q;
  logic                  vld_q, busy_q;

  // Binary angle table, 256 units per turn.
  function automatic logic [DW-1:0] ang(input logic [2:0] i);
    case (i)
      3'd0:    ang = DW'(32);
      3'd1:    ang = DW'(18);
      3'd2:    ang = DW'(9);
      3'd3:    ang = DW'(5);
      3'd4:    ang = DW'(2);
      3'd5:    ang = DW'(1);
      default: ang = '0;
    endcase
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [W-1:0] v);
    if (v > MAXV)      sat = MAXV[DW-1:0];
    else if (v < MINV) sat = MINV[DW-1:0];
    else               sat = v[DW-1:0];
  endfunction

  // Quadrant pre-rotation brings the vector into the right half-plane; the two guard
  // bits keep negation of the most negative input exact.
  logic signed [W-1:0] xe, ye, px_d, py_d;
  logic [DW-1:0]       pz_d;

  assign xe = {{2{x_i[N_FRAC]}}, x_i};
  assign ye = {{2{y_i[N_FRAC]}}, y_i};

  always_comb begin
    px_d = xe;
    py_d = ye;
    pz_d = z_i;
    if (x_i[N_FRAC]) begin
      if (!y_i[N_FRAC]) begin
        px_d = ye;
        py_d = -xe;
        pz_d = z_i + QTR;
      end else begin
        px_d = -ye;
        py_d = xe;
        pz_d = z_i - QTR;
      end
    end
  end

  logic signed [W-1:0] xs, ys, x_d, y_d;
  logic [DW-1:0]       z_d;

  assign xs = x_q >>> cnt_q;
  assign ys = y_q >>> cnt_q;

  always_comb begin
    if (!y_q[W-1]) begin
      x_d = x_q + ys;
      y_d = y_q - xs;
      z_d = z_q + ang(cnt_q);
    end else begin
      x_d = x_q - ys;
      y_d = y_q + xs;
      z_d = z_q - ang(cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_in_valid_strobe_i) begin
            x_q     <= px_d;
            y_q     <= py_d;
            z_q     <= pz_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'(ITERS - 1)) begin
            xo_q    <= sat(x_d);
            yo_q    <= sat(y_d);
            zo_q    <= z_d;
            vld_q   <= 1'b1;
            state_q <= OUTPUT;
          end
        end
        OUTPUT: begin
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign x_o                     = xo_q;
  assign y_o                     = yo_q;
  assign z_o                     = zo_q;
  assign data_out_valid_strobe_o = vld_q;
  assign busy_o                  = busy_q;

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// Scoreboard bench for the vectoring CORDIC: a bit-exact model queues expected results
// and cycle of arrival; a monitor pops and compares on every output strobe.
module tb_cordic_vectoring_iterative;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [7:0] x, y, z, xo, yo, zo;
  logic vin, vout, busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic signed [7:0] x, y, z;
    int cyc;
  } exp_t;
  exp_t q[$];

  cordic_vectoring_iterative #(.N_FRAC(7)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .x_i(x), .y_i(y), .z_i(z), .data_in_valid_strobe_i(vin),
    .x_o(xo), .y_o(yo), .z_o(zo), .data_out_valid_strobe_o(vout), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 127) ? 127 : (v < -128) ? -128 : v;
  endfunction

  function automatic exp_t model(input int xi, input int yi, input int zi);
    int   xx, yy, zz, xn;
    int   ang[6] = '{32, 18, 9, 5, 2, 1};
    exp_t r;
    if (xi >= 0)      begin xx = xi;  yy = yi;  zz = zi;      end
    else if (yi >= 0) begin xx = yi;  yy = -xi; zz = zi + 64; end
    else              begin xx = -yi; yy = xi;  zz = zi - 64; end
    for (int i = 0; i < 6; i++) begin
      if (yy >= 0) begin xn = xx + (yy >>> i); yy = yy - (xx >>> i); zz = zz + ang[i]; end
      else         begin xn = xx - (yy >>> i); yy = yy + (xx >>> i); zz = zz - ang[i]; end
      xx = xn;
    end
    r.x = 8'(sat8(xx));
    r.y = 8'(sat8(yy));
    r.z = 8'(zz);
    r.cyc = 0;
    return r;
  endfunction

  // Drive values on the falling edge; if accepted, queue the model result due 7 edges later.
  task automatic drive(input int xv, input int yv, input int zv, input bit acc);
    exp_t e;
    @(negedge clk);
    x = 8'(xv); y = 8'(yv); z = 8'(zv); vin = 1'b1;
    if (acc) begin
      e = model(x, y, z);
      e.cyc = cyc + 7;
      q.push_back(e);
    end
  endtask

  task automatic send(input int xv, input int yv, input int zv);
    drive(xv, yv, zv, 1'b1);
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) return;
    end
    chk("timeout", 0, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && vout) begin
        if (q.size() == 0) chk("spurious_strobe", 1, 0);
        else begin
          e = q.pop_front();
          chk("x_o", xo, e.x);
          chk("y_o", yo, e.y);
          chk("z_o", zo, e.z);
          chk("latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    vin = 1'b0; x = '0; y = '0; z = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_x", xo, 0); chk("rst_y", yo, 0); chk("rst_z", zo, 0);
    chk("rst_vld", vout, 0); chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic vector with busy timing.
    send(64, 0, 0);
    chk("busy_e0", busy, 1);
    repeat (6) @(posedge clk);
    #1 chk("busy_e6", busy, 1);
    @(posedge clk);
    #1 chk("busy_e7", busy, 0);
    chk("vld_e7", vout, 0);
    wait_done();
    chk("t1_x", xo, 106); chk("t1_y", yo, 2); chk("t1_z", zo, 1);

    send(-64, 0, 0);
    wait_done();
    chk("t2_x", xo, 106); chk("t2_y", yo, -2); chk("t2_z", zo, 127);

    send(127, 127, 0);
    wait_done();
    chk("t3_xsat", xo, 127);
    chk("t3_z45", int'(zo >= 31 && zo <= 33), 1);
    send(-128, -128, 0);
    wait_done();
    chk("t3b_xsat", xo, 127);
    chk("t3b_z", int'(zo >= -98 && zo <= -94), 1);

    // Strobe held for 9 cycles: first and last accepted, the seven between ignored.
    for (int k = 0; k < 9; k++)
      drive(10 * k - 40, 25 - 7 * k, 3 * k, (k == 0 || k == 8));
    @(negedge clk);
    vin = 1'b0;
    wait_done();

    // Reset in the middle of CALC aborts without a strobe.
    send(50, -30, 10);
    repeat (2) @(negedge clk);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", xo, 0); chk("mid_rst_y", yo, 0); chk("mid_rst_z", zo, 0);
    chk("mid_rst_vld", vout, 0); chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    send(64, 0, 0);
    wait_done();
    chk("post_rst_x", xo, 106); chk("post_rst_z", zo, 1);

    send(0, 0, 0);       wait_done();
    send(-128, 0, 5);    wait_done();
    send(0, -128, -100); wait_done();
    send(-1, -1, 127);   wait_done();
    send(127, -128, 64); wait_done();
    for (int n = 0; n < 24; n++) begin
      send($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
           $urandom_range(0, 255) - 128);
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
